// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Purpose : Shared types and constants for the two-requester memory arbiter.
//           Holds the FSM state enum, requester count, default bus widths
//           and a small one-hot helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // One-hot vector selecting requester 'idx'.
  function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-input round-robin choice with a registered priority pointer.
//           A lone valid requester always wins; on contention the pointer
//           decides. After each grant the pointer moves to the requester
//           that did not win, so neither side can be starved.
// Ports   : clock    - rising-edge clock
//           reset_n  - asynchronous active-low reset (pointer -> requester 0)
//           valid    - per-requester request bits
//           enable   - grants may be issued this cycle
//           grant    - combinational one-hot grant (0 when disabled)
//           winner   - index of the chosen requester (meaningful with grant)
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic               winner
);

  logic ptr;

  always_comb begin
    winner = 1'b0;
    unique case (valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ptr;
      default: winner = 1'b0;
    endcase
    grant = (enable && (|valid)) ? onehot(winner) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= ~winner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Arbitrates two requesters onto a single-port RAM with a
//           combinational read path. IDLE grants (combinationally) and latches
//           the winner's access; ACCESS drives the RAM for one cycle; the
//           completion pulse follows in the next IDLE cycle, which may itself
//           carry a new grant. Peak rate: one access every two cycles.
// Ports   : clock, reset_n          - clock, asynchronous active-low reset
//           req_valid/wr/addr/wdata - per-requester request (req 0 in low bits)
//           req_grant               - one-hot grant pulse
//           rsp_valid, rsp_rdata    - one-hot completion pulse, read data
//           mem_address/data/wr/cs  - RAM interface (cs active-low)
//           mem_o                   - RAM combinational read data
//           grant_cnt0/1            - saturating grant counters (optional)
// Config  : define MEM_ARBITER_STATS_EN to add grant_cnt0/grant_cnt1.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_wr,
  output logic                      mem_cs,
  input  logic [DATA_W-1:0]         mem_o
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0]               grant_cnt0,
  output logic [15:0]               grant_cnt1
`endif
);

  state_t             state;
  logic               owner;
  logic               winner;
  logic               grant_en;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Gating with reset_n keeps req_grant low for the whole reset window,
  // not just after the first edge.
  assign grant_en = (state == IDLE) && reset_n;

  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (req_valid),
    .enable  (grant_en),
    .grant   (req_grant),
    .winner  (winner)
  );

  assign sel_wr    = winner ? req_wr[1] : req_wr[0];
  assign sel_addr  = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wdata = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // The RAM-side outputs double as the latched request, so an asynchronous
  // reset during ACCESS releases mem_cs at once and drops the response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      mem_cs      <= 1'b1;
      mem_wr      <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (|req_grant) begin
            state       <= ACCESS;
            owner       <= winner;
            mem_cs      <= 1'b0;
            mem_wr      <= sel_wr;
            mem_address <= sel_addr;
            mem_data    <= sel_wdata;
          end
        end
        ACCESS: begin
          state       <= IDLE;
          mem_cs      <= 1'b1;
          mem_wr      <= 1'b0;
          mem_address <= '0;
          mem_data    <= '0;
          rsp_valid   <= onehot(owner);
          // Writes leave the previous read data in place.
          if (!mem_wr) begin
            rsp_rdata <= mem_o;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (req_grant[0] && (cnt0 != 16'hFFFF)) begin
        cnt0 <= cnt0 + 16'd1;
      end
      if (req_grant[1] && (cnt1 != 16'hFFFF)) begin
        cnt1 <= cnt1 + 16'd1;
      end
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter: directed transaction table,
//           hand-written contention / single-requester / reset-abort
//           sequences, optional statistics checks, and a randomized run
//           against a timestamp-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_grant;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_cs;
  logic [7:0]  mem_o;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] ram [0:255];

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_grant   (req_grant),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wr      (mem_wr),
    .mem_cs      (mem_cs),
    .mem_o       (mem_o)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural RAM: combinational read, write on the rising edge under cs.
  assign mem_o = ram[mem_address];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clock);
      if (!mem_cs && mem_wr) ram[mem_address] <= mem_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_req(input int who, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    req_valid[who]        = v;
    req_wr[who]           = w;
    req_addr[who*8 +: 8]  = a;
    req_wdata[who*8 +: 8] = d;
  endtask

  // Reset with requests already presented; releases on a falling edge so the
  // caller's first sample (#1 later) is inside the first post-reset cycle.
  task automatic apply_reset(input logic [1:0] v);
    @(negedge clock);
    reset_n = 1'b0;
    set_req(0, v[0], 1'b0, 8'h10, 8'h00);
    set_req(1, v[1], 1'b0, 8'hFF, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int         who;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [7];

  task automatic run_txn(input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.who;
    @(posedge clock); #1;
    set_req(v.who, 1'b1, v.wr, v.addr, v.wdata);
    @(negedge clock);
    check("tbl_grant", 32'(req_grant), 32'(oh));
    check("tbl_idle_cs", 32'(mem_cs), 32'(1));
    @(posedge clock); #1;
    set_req(v.who, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    check("tbl_acc_cs", 32'(mem_cs), 32'(0));
    check("tbl_acc_addr", 32'(mem_address), 32'(v.addr));
    check("tbl_acc_wr", 32'(mem_wr), 32'(v.wr));
    check("tbl_acc_data", 32'(mem_data), 32'(v.wdata));
    check("tbl_acc_nogrant", 32'(req_grant), 32'(0));
    @(posedge clock); #1;
    @(negedge clock);
    check("tbl_rsp_valid", 32'(rsp_valid), 32'(oh));
    check("tbl_rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
  endtask

  // Continuous requests from the set in 'v'; grants must land on even cycles,
  // alternating when both compete, with each response two cycles after.
  task automatic run_stream(input string name, input logic [1:0] v, input int n);
    logic [1:0] exp_g [16];
    for (int c = 0; c < n; c++) begin
      if (c % 2 != 0)        exp_g[c] = 2'b00;
      else if (v == 2'b11)   exp_g[c] = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
      else                   exp_g[c] = v;
    end
    apply_reset(v);
    #1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clock);
      check({name, "_grant"}, 32'(req_grant), 32'(exp_g[c]));
      check({name, "_cs"}, 32'(mem_cs), 32'((c % 2 == 1) ? 0 : 1));
      check({name, "_rsp"}, 32'(rsp_valid), 32'((c >= 2) ? exp_g[c-2] : 2'b00));
      @(posedge clock);
    end
  endtask

`ifdef MEM_ARBITER_STATS_EN
  task automatic one_grant(input int who);
    @(posedge clock); #1;
    set_req(who, 1'b1, 1'b0, 8'h01, 8'h00);
    @(negedge clock);
    @(posedge clock); #1;
    set_req(who, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    @(negedge clock);
  endtask
`endif

  // Reference-model state for the randomized run.
  logic [7:0] ram_m [0:255];

  initial begin
    int         ptr_m, next_ok, acc_c, rsp_c, rsp_who, win;
    logic       rsp_wr, acc_w;
    logic [7:0] rsp_d, last_rd, acc_a, acc_d;
    logic [1:0] exp_g;

    reset_n   = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // ---- reset state, with both requests pending ----
    #3;
    reset_n = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h12, 8'h34);
    set_req(1, 1'b1, 1'b0, 8'h56, 8'h00);
    @(negedge clock);
    @(negedge clock);
    check("rst_grant", 32'(req_grant), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    check("rst_cs", 32'(mem_cs), 32'(1));
    check("rst_wr", 32'(mem_wr), 32'(0));
    check("rst_addr", 32'(mem_address), 32'(0));
    check("rst_data", 32'(mem_data), 32'(0));
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    reset_n = 1'b1;

    // ---- directed transaction table ----
    tbl[0] = '{1, 1'b1, 8'hFF, 8'h3C, 8'h00};  // write keeps rdata from reset
    tbl[1] = '{1, 1'b0, 8'hFF, 8'h00, 8'h3C};  // read back own write
    tbl[2] = '{0, 1'b1, 8'h10, 8'hA5, 8'h3C};
    tbl[3] = '{0, 1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[4] = '{0, 1'b0, 8'h11, 8'h00, 8'h4B};  // untouched: 0x11 ^ 0x5A
    tbl[5] = '{1, 1'b1, 8'h11, 8'h00, 8'h4B};
    tbl[6] = '{1, 1'b0, 8'h11, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // ---- contention and lone requester 1 ----
    run_stream("cont", 2'b11, 9);
    run_stream("solo1", 2'b10, 9);

    // ---- reset during the ACCESS of a write ----
    apply_reset(2'b00);
    @(posedge clock); #1;
    set_req(0, 1'b1, 1'b1, 8'h20, 8'h77);
    @(negedge clock);
    check("abort_grant", 32'(req_grant), 32'(1));
    @(posedge clock); #1;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    check("abort_cs_before", 32'(mem_cs), 32'(0));
    reset_n = 1'b0;
    #1;
    check("abort_cs_async", 32'(mem_cs), 32'(1));
    @(posedge clock); #1;
    check("abort_ram", 32'(ram[8'h20]), 32'(8'h7A));
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("abort_no_rsp", 32'(rsp_valid), 32'(0));
      @(negedge clock);
    end
    check("abort_ram_after", 32'(ram[8'h20]), 32'(8'h7A));

`ifdef MEM_ARBITER_STATS_EN
    // ---- grant counters ----
    apply_reset(2'b00);
    #1;
    check("cnt0_reset", 32'(grant_cnt0), 32'(0));
    check("cnt1_reset", 32'(grant_cnt1), 32'(0));
    for (int i = 0; i < 8; i++) one_grant((i < 5) ? 0 : 1);
    check("cnt0_five", 32'(grant_cnt0), 32'(5));
    check("cnt1_three", 32'(grant_cnt1), 32'(3));
    force dut.cnt0 = 16'hFFFF;
    @(negedge clock);
    release dut.cnt0;
    one_grant(0);
    check("cnt0_saturate", 32'(grant_cnt0), 32'(16'hFFFF));
    check("cnt1_hold", 32'(grant_cnt1), 32'(3));
`endif

    // ---- randomized run against the reference model ----
    apply_reset(2'b00);
    for (int i = 0; i < 256; i++) ram_m[i] = ram[i];
    ptr_m   = 0;
    next_ok = 0;
    acc_c   = -1;
    rsp_c   = -1;
    rsp_who = 0;
    rsp_wr  = 1'b0;
    rsp_d   = 8'h00;
    last_rd = 8'h00;
    acc_w   = 1'b0;
    acc_a   = 8'h00;
    acc_d   = 8'h00;
    #1;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clock);
      // Expected grant: bus free (two cycles since last grant) and a request.
      win   = -1;
      exp_g = 2'b00;
      if (c >= next_ok && req_valid != 2'b00) begin
        if (req_valid == 2'b11) win = ptr_m;
        else                    win = req_valid[1] ? 1 : 0;
        exp_g = 2'b01 << win;
      end
      check("rnd_grant", 32'(req_grant), 32'(exp_g));
      check("rnd_cs", 32'(mem_cs), 32'((c == acc_c) ? 0 : 1));
      if (c == acc_c) begin
        check("rnd_addr", 32'(mem_address), 32'(acc_a));
        check("rnd_wr", 32'(mem_wr), 32'(acc_w));
        check("rnd_data", 32'(mem_data), 32'(acc_d));
      end
      if (c == rsp_c) begin
        if (!rsp_wr) last_rd = rsp_d;
        check("rnd_rsp_valid", 32'(rsp_valid), 32'(2'b01 << rsp_who));
      end else begin
        check("rnd_rsp_valid", 32'(rsp_valid), 32'(0));
      end
      check("rnd_rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
      if (win >= 0) begin
        ptr_m   = 1 - win;
        next_ok = c + 2;
        acc_c   = c + 1;
        rsp_c   = c + 2;
        rsp_who = win;
        acc_w   = req_wr[win];
        acc_a   = req_addr[win*8 +: 8];
        acc_d   = req_wdata[win*8 +: 8];
        rsp_wr  = acc_w;
        if (acc_w) ram_m[acc_a] = acc_d;
        else       rsp_d = ram_m[acc_a];
      end
      @(posedge clock); #1;
      for (int k = 0; k < 2; k++) begin
        if (exp_g[k] || (!req_valid[k] && $urandom_range(0, 2) == 0)) begin
          set_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
